// File: rtl/mpsoc_sysinfo.sv
// System-identification and housekeeping slave: build ID registers, uptime counter with
// coherent lo/hi readout, per-CPU scratch registers and one boot-arbitration mutex.
module mpsoc_sysinfo #(
  parameter logic [31:0] SYS_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter int unsigned NUM_CPUS  = 2,
  parameter int unsigned CNT_W     = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      scratch_q [NUM_CPUS];
  logic [31:0]      scratch_d [NUM_CPUS];
  logic             locked_q, locked_d;
  logic [7:0]       owner_q, owner_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic        rd_acc;
  logic        clr;
  logic [63:0] cnt_ext;
  logic [31:0] rd_mux;

  // A simultaneous write wins; the read is dropped.
  assign rd_acc  = read & ~write;
  assign cnt_ext = 64'(cnt_q);

  always_comb begin
    rd_mux = '0;
    case (address)
      4'd0: rd_mux = SYS_ID;
      4'd1: rd_mux = TIMESTAMP;
      4'd2: rd_mux = {16'h0000, 8'(CNT_W), 8'(NUM_CPUS)};
      4'd3: rd_mux = {31'h0, en_q};
      4'd4: rd_mux = cnt_ext[31:0];
      4'd5: rd_mux = hi_q;
      4'd6: rd_mux = {16'h0000, owner_q, 7'h00, locked_q};
      default: begin
        for (int i = 0; i < int'(NUM_CPUS); i++) begin
          if (address == 4'(8 + i)) rd_mux = scratch_q[i];
        end
      end
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    en_d      = en_q;
    hi_d      = hi_q;
    scratch_d = scratch_q;
    locked_d  = locked_q;
    owner_d   = owner_q;
    rdata_d   = rdata_q;
    rvalid_d  = rd_acc;
    clr       = 1'b0;

    if (write) begin
      case (address)
        4'd3: begin
          en_d = writedata[0];
          clr  = writedata[1];
        end
        4'd6: begin
          if (writedata[0]) begin
            if (!locked_q) begin
              locked_d = 1'b1;
              owner_d  = writedata[15:8];
            end
          end else if (locked_q && (writedata[15:8] == owner_q)) begin
            locked_d = 1'b0;
            owner_d  = 8'h00;
          end
        end
        default: begin
          for (int i = 0; i < int'(NUM_CPUS); i++) begin
            if (address == 4'(8 + i)) scratch_d[i] = writedata;
          end
        end
      endcase
    end

    // Clear overrides the increment; the increment uses the enable in force before this edge.
    if (clr) begin
      cnt_d = '0;
    end else if (en_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (rd_acc) begin
      rdata_d = rd_mux;
      // Snapshot the upper half together with the low read so LO-then-HI is coherent.
      if (address == 4'd4) hi_d = cnt_ext[63:32];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      en_q      <= 1'b1;
      hi_q      <= '0;
      scratch_q <= '{default: '0};
      locked_q  <= 1'b0;
      owner_q   <= 8'h00;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      hi_q      <= hi_d;
      scratch_q <= scratch_d;
      locked_q  <= locked_d;
      owner_q   <= owner_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_mpsoc_sysinfo.sv
// Bench for mpsoc_sysinfo: directed scenarios plus a randomized bus run checked against a
// transaction-level model of the register map.
module tb_mpsoc_sysinfo;

  localparam logic [31:0] SysId = 32'h694B_7A36;
  localparam logic [31:0] Ts    = 32'h5F00_1234;
  localparam int          NCpu  = 4;
  localparam int          CntW  = 48;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int chk_cnt = 0;
  int pass_cnt = 0;

  mpsoc_sysinfo #(
    .SYS_ID   (SysId),
    .TIMESTAMP(Ts),
    .NUM_CPUS (NCpu),
    .CNT_W    (CntW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  // Reference model: architectural state updated once per clock from the bus inputs.
  logic [63:0] cnt_mask = (64'd1 << CntW) - 64'd1;
  logic [63:0] m_cnt = '0;
  logic [63:0] m_nxt;
  bit          m_en = 1'b1;
  bit          m_clr;
  logic [31:0] m_hi = '0;
  logic [31:0] m_scr [NCpu];
  bit          m_locked = 1'b0;
  logic [7:0]  m_owner = '0;
  logic [31:0] m_rdata = '0;
  bit          m_rvalid = 1'b0;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    int ai = int'(a);
    if (ai == 0) return SysId;
    if (ai == 1) return Ts;
    if (ai == 2) return 32'((CntW << 8) | NCpu);
    if (ai == 3) return {31'h0, m_en};
    if (ai == 4) return m_cnt[31:0];
    if (ai == 5) return m_hi;
    if (ai == 6) return {16'h0, m_owner, 7'h0, m_locked};
    if (ai >= 8 && ai < 8 + NCpu) return m_scr[ai - 8];
    return 32'h0;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      m_cnt = '0; m_en = 1'b1; m_hi = '0; m_locked = 1'b0; m_owner = '0;
      m_rdata = '0; m_rvalid = 1'b0;
      for (int i = 0; i < NCpu; i++) m_scr[i] = '0;
    end else begin
      m_clr = 1'b0;
      m_rvalid = read && !write;
      if (m_rvalid) begin
        m_rdata = m_read(address);
        if (address == 4'd4) m_hi = 32'(m_cnt >> 32);
      end
      if (write) begin
        if (address == 4'd3) m_clr = writedata[1];
        if (address == 4'd6) begin
          if (writedata[0] && !m_locked) begin
            m_locked = 1'b1; m_owner = writedata[15:8];
          end else if (!writedata[0] && m_locked && writedata[15:8] == m_owner) begin
            m_locked = 1'b0; m_owner = '0;
          end
        end
        if (int'(address) >= 8 && int'(address) < 8 + NCpu) m_scr[int'(address) - 8] = writedata;
      end
      m_nxt = m_clr ? 64'd0 : (m_en ? ((m_cnt + 64'd1) & cnt_mask) : m_cnt);
      if (write && address == 4'd3) m_en = writedata[0];
      m_cnt = m_nxt;
    end
  end

  // Bus drivers: entered at a negedge, leave at the following negedge with strobes low.
  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    address = a; read = 1'b1; write = 1'b0;
    @(negedge clock);
    d = readdata; v = readdatavalid;
    read = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] wd);
    address = a; writedata = wd; write = 1'b1; read = 1'b0;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    chk_cnt++;
    if (readdatavalid !== 1'b0) $display("FAIL reset_rvalid got %b want 0", readdatavalid);
    else pass_cnt++;
    chk_cnt++;
    if (readdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", readdata);
    else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_id_regs();
    logic [31:0] exp_tab [3];
    logic [31:0] d;
    logic v;
    exp_tab = '{32'h694B_7A36, 32'h5F00_1234, 32'h0000_3004};
    for (int i = 0; i < 3; i++) begin
      bus_read(4'(i), d, v);
      chk_cnt++;
      if (v !== 1'b1 || d !== exp_tab[i])
        $display("FAIL id_word%0d got v=%b %h want v=1 %h", i, v, d, exp_tab[i]);
      else pass_cnt++;
    end
    idle(1);
    chk_cnt++;
    if (readdatavalid !== 1'b0) $display("FAIL id_rvalid_idle got %b want 0", readdatavalid);
    else pass_cnt++;
  endtask

  task automatic test_uptime_boundary();
    logic [31:0] d;
    logic v;
    int n;
    bus_write(4'd3, 32'h0);
    force dut.cnt_q = 48'h0000_FFFF_FFFD;
    m_cnt = 64'h0000_FFFF_FFFD;
    @(negedge clock);
    release dut.cnt_q;
    bus_write(4'd3, 32'h1);
    n = 0;
    while (m_cnt[31:0] != 32'hFFFF_FFFF && n < 20) begin
      idle(1);
      n++;
    end
    chk_cnt++;
    if (n >= 20) $display("FAIL uptime_reach_boundary got timeout want counter at FFFFFFFF");
    else pass_cnt++;
    bus_read(4'd4, d, v);
    chk_cnt++;
    if (v !== 1'b1 || d !== 32'hFFFF_FFFF)
      $display("FAIL uptime_lo_boundary got v=%b %h want v=1 ffffffff", v, d);
    else pass_cnt++;
    idle(10);
    bus_read(4'd5, d, v);
    chk_cnt++;
    if (v !== 1'b1 || d !== 32'h0) $display("FAIL uptime_hi_shadow got v=%b %h want v=1 0", v, d);
    else pass_cnt++;
    bus_read(4'd4, d, v);
    chk_cnt++;
    if (d !== m_rdata) $display("FAIL uptime_lo_after_carry got %h want %h", d, m_rdata);
    else pass_cnt++;
    bus_read(4'd5, d, v);
    chk_cnt++;
    if (d !== 32'h1) $display("FAIL uptime_hi_after_carry got %h want 1", d);
    else pass_cnt++;
  endtask

  task automatic test_freeze_clear();
    logic [31:0] d0, d1;
    logic v;
    bus_write(4'd3, 32'h0);
    bus_read(4'd4, d0, v);
    idle(20);
    bus_read(4'd4, d1, v);
    chk_cnt++;
    if (d1 !== m_rdata || d0 !== d1)
      $display("FAIL freeze_hold got %h then %h want %h", d0, d1, m_rdata);
    else pass_cnt++;
    bus_write(4'd3, 32'h3);
    bus_read(4'd4, d0, v);
    chk_cnt++;
    if (v !== 1'b1 || d0 > 32'd3) $display("FAIL clear_lo got v=%b %h want v=1 <=3", v, d0);
    else pass_cnt++;
    bus_read(4'd3, d0, v);
    chk_cnt++;
    if (d0 !== 32'h1) $display("FAIL ctrl_readback got %h want 1", d0);
    else pass_cnt++;
  endtask

  task automatic test_mutex();
    logic [31:0] wr_tab [4];
    logic [31:0] exp_tab [4];
    logic [31:0] d;
    logic v;
    wr_tab  = '{32'h0000_0101, 32'h0000_0201, 32'h0000_0200, 32'h0000_0100};
    exp_tab = '{32'h0000_0101, 32'h0000_0101, 32'h0000_0101, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      bus_write(4'd6, wr_tab[i]);
      bus_read(4'd6, d, v);
      chk_cnt++;
      if (d !== exp_tab[i])
        $display("FAIL mutex_step%0d got %h want %h", i, d, exp_tab[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    logic v;
    for (int i = 0; i < NCpu; i++) bus_write(4'(8 + i), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < NCpu; i++) begin
      bus_read(4'(8 + i), d, v);
      chk_cnt++;
      if (d !== 32'hA5A5_0000 + 32'(i))
        $display("FAIL scratch%0d got %h want %h", i, d, 32'hA5A5_0000 + 32'(i));
      else pass_cnt++;
    end
    bus_read(4'd12, d, v);
    chk_cnt++;
    if (v !== 1'b1 || d !== 32'h0) $display("FAIL unmapped12 got v=%b %h want v=1 0", v, d);
    else pass_cnt++;
    bus_read(4'd7, d, v);
    chk_cnt++;
    if (d !== 32'h0) $display("FAIL reserved7 got %h want 0", d);
    else pass_cnt++;
    bus_write(4'd12, 32'hDEAD_BEEF);
    bus_read(4'd11, d, v);
    chk_cnt++;
    if (d !== 32'hA5A5_0003) $display("FAIL scratch3_after_w12 got %h want a5a50003", d);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [31:0] wd;
    logic [31:0] d;
    logic v;
    wd = $urandom;
    address = 4'd9; writedata = wd; read = 1'b1; write = 1'b1;
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    chk_cnt++;
    if (readdatavalid !== 1'b0) $display("FAIL collide_rvalid got %b want 0", readdatavalid);
    else pass_cnt++;
    bus_read(4'd9, d, v);
    chk_cnt++;
    if (d !== wd) $display("FAIL collide_write got %h want %h", d, wd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v;
    bus_write(4'd6, 32'h0000_0301);
    address = 4'd0; read = 1'b1; reset_n = 1'b0;
    @(negedge clock);
    read = 1'b0; reset_n = 1'b1;
    chk_cnt++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0)
      $display("FAIL rstmid_rvalid got v=%b %h want v=0 0", readdatavalid, readdata);
    else pass_cnt++;
    bus_read(4'd4, d, v);
    chk_cnt++;
    if (d !== 32'h0) $display("FAIL rstmid_counter got %h want 0", d);
    else pass_cnt++;
    for (int i = 0; i < NCpu; i++) begin
      bus_read(4'(8 + i), d, v);
      chk_cnt++;
      if (d !== 32'h0) $display("FAIL rstmid_scratch%0d got %h want 0", i, d);
      else pass_cnt++;
    end
    bus_read(4'd6, d, v);
    chk_cnt++;
    if (d !== 32'h0) $display("FAIL rstmid_mutex got %h want 0", d);
    else pass_cnt++;
    bus_read(4'd3, d, v);
    chk_cnt++;
    if (d !== 32'h1) $display("FAIL rstmid_ctrl got %h want 1", d);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int op;
    int errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 9));
      address = 4'($urandom_range(0, 15));
      if (address == 4'd6)
        writedata = {16'h0, 8'($urandom_range(1, 3)), 7'h0, 1'($urandom_range(0, 1))};
      else if (address == 4'd3)
        writedata = {30'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)};
      else
        writedata = $urandom;
      read  = (op < 5) || (op == 9);
      write = (op >= 5 && op < 8) || (op == 9);
      @(negedge clock);
      read = 1'b0; write = 1'b0;
      chk_cnt++;
      if (readdatavalid !== m_rvalid || readdata !== m_rdata) begin
        if (errs < 10)
          $display("FAIL random_cycle%0d got v=%b %h want v=%b %h", n, readdatavalid,
                   readdata, m_rvalid, m_rdata);
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_id_regs();
    test_uptime_boundary();
    test_freeze_clear();
    test_mutex();
    test_scratch();
    test_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
